vldst_seq: RTL and testbench
============================

VLDST_SEQ -- requirements
Module: vldst_seq

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of the data memory port.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request a vector transfer; sampled only in IDLE.
REQ-005 is_store  input  1  1 = store vector to memory (STV_W), 0 = load vector from memory (LDV_W); sampled with start.
REQ-006 base_addr  input  ADDR_W  byte address of lane 0; sampled with start.
REQ-007 vreg  input  5  vector register index; sampled with start.
REQ-008 busy  output  1  high from the cycle after acceptance through the DONE cycle; CPU holds the PC while high.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 err  output  1  one-cycle pulse for a rejected misaligned request.
REQ-011 mem_addr  output  ADDR_W  data memory address.
REQ-012 mem_wr_en  output  1  data memory write enable.
REQ-013 mem_wdata  output  32  data to memory.
REQ-014 mem_rdata  input  32  data from memory, combinational read of mem_addr.
REQ-015 vrf_raddr  output  5  vector regfile read index.
REQ-016 vrf_rdata  input  128  vector regfile read data, combinational.
REQ-017 vrf_waddr  output  5  vector regfile write index.
REQ-018 vrf_wdata  output  128  vector regfile write data.
REQ-019 vrf_we  output  1  vector regfile write enable.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, STORE, DONE; 2-bit beat counter 0..3.
REQ-021 Lane i SHALL map to byte address base_addr + 4*i and to vector bits [127-32*i : 96-32*i]; lane 0 occupies the MSBs.
REQ-022 In IDLE, vrf_raddr SHALL follow vreg combinationally; otherwise it SHALL hold the latched index.
REQ-023 In IDLE with start=1 and base_addr[1:0]=0, the block SHALL latch base_addr, vreg and is_store, and enter LOAD or STORE with beat=0; for a store it SHALL also latch vrf_rdata in the same edge.
REQ-024 In IDLE with start=1 and base_addr[1:0]!=0, the block SHALL stay in IDLE, assert err for exactly the next cycle, and perform no memory or regfile write.
REQ-025 In LOAD, each cycle SHALL drive mem_addr = latched base + 4*beat with mem_wr_en=0, and capture mem_rdata into lane beat at the clock edge.
REQ-026 In STORE, each cycle SHALL drive mem_addr = latched base + 4*beat, mem_wr_en=1 and mem_wdata = latched lane beat.
REQ-027 After beat 3, LOAD and STORE SHALL go to DONE; DONE SHALL last one cycle and then go to IDLE.
REQ-028 In DONE, done=1; if the operation was a load, vrf_we=1, vrf_waddr = latched vreg and vrf_wdata = assembled vector; otherwise vrf_we=0.
REQ-029 Latency: acceptance at cycle 0, beats in cycles 1-4, DONE in cycle 5, next acceptance at cycle 6 at the earliest.
REQ-030 busy SHALL be 1 in LOAD, STORE and DONE, and 0 in IDLE.
REQ-031 start SHALL be ignored while busy=1; no queuing.
REQ-032 Address arithmetic SHALL be modulo 2^ADDR_W; base 0xFFFFFFF8 gives lane addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-033 Outside LOAD and STORE, mem_wr_en SHALL be 0 and mem_addr SHALL be 0; outside DONE, vrf_we SHALL be 0.

Reset
REQ-034 On rst_n=0 at a rising edge, the block SHALL enter IDLE, clear the beat counter, lane buffer and latched fields to 0, and drive busy, done, err, mem_wr_en and vrf_we to 0.
REQ-035 Reset mid-load SHALL discard partial data with no vrf write; reset mid-store SHALL leave already-written beats in memory and issue no further writes.
REQ-036 rst_n=0 SHALL override start in the same cycle.

Verification
REQ-037 Load: memory 0x40..0x4C = 11111111, 22222222, 33333333, 44444444; start with is_store=0, base 0x40, vreg 3 -> mem_addr 40, 44, 48, 4C in cycles 1-4; cycle 5 vrf_we=1, waddr 3, wdata 11111111_22222222_33333333_44444444, done=1.
REQ-038 Store: v5 = AAAA0000_BBBB0000_CCCC0000_DDDD0000; start with is_store=1, base 0x100 -> four writes to 100, 104, 108, 10C with those words in order; done in cycle 5; vrf_we stays 0.
REQ-039 Misaligned: base 0x42 -> err=1 for one cycle, busy stays 0, no mem_wr_en and no vrf_we.
REQ-040 Busy/back-to-back: start held high continuously -> accepted in cycles 0 and 6 only; second transfer correct.
REQ-041 Wrap: store with base 0xFFFFFFF8 -> addresses FFFFFFF8, FFFFFFFC, 0, 4.
REQ-042 Reset mid-load in cycle 3 -> next cycle IDLE, all outputs 0, no vrf_we ever asserted for that load.

Source files
------------

// File: rtl/vldst_seq_if.sv
// vldst_seq_if -- bundle of every signal between the vector load/store
// sequencer and its surroundings. This covers the CPU request/status lines,
// the data memory port and the vector register file port.
//
//   start, is_store, base_addr, vreg : transfer request from the CPU
//   busy, done, err                  : status back to the CPU
//   mem_addr, mem_wr_en, mem_wdata   : data memory request
//   mem_rdata                        : data memory combinational read data
//   vrf_raddr / vrf_rdata            : vector regfile read port
//   vrf_waddr, vrf_wdata, vrf_we     : vector regfile write port
//
// modport slave  : the sequencer itself
// modport master : the environment (CPU, memory and regfile side)
interface vldst_seq_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic              is_store;
  logic [ADDR_W-1:0] base_addr;
  logic [4:0]        vreg;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_en;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic [4:0]        vrf_raddr;
  logic [127:0]      vrf_rdata;
  logic [4:0]        vrf_waddr;
  logic [127:0]      vrf_wdata;
  logic              vrf_we;

  modport slave (
    input  start, is_store, base_addr, vreg, mem_rdata, vrf_rdata,
    output busy, done, err, mem_addr, mem_wr_en, mem_wdata,
           vrf_raddr, vrf_waddr, vrf_wdata, vrf_we
  );

  modport master (
    output start, is_store, base_addr, vreg, mem_rdata, vrf_rdata,
    input  busy, done, err, mem_addr, mem_wr_en, mem_wdata,
           vrf_raddr, vrf_waddr, vrf_wdata, vrf_we
  );
endinterface

// File: rtl/vldst_seq.sv
// vldst_seq -- moves one 128-bit vector register to or from four consecutive
// 32-bit words of data memory, one word per cycle.
//
// Lane i lives at byte address base + 4*i and in vector bits
// [127-32*i : 96-32*i], so lane 0 is the most significant word.
//
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : vldst_seq_if.slave -- CPU request/status, memory port, regfile port
//
// Timing: the request is accepted in cycle 0, the beats run in cycles 1-4,
// DONE is cycle 5, and the next request can be accepted in cycle 6.
// A misaligned base is rejected with a one-cycle err pulse.
module vldst_seq #(
  parameter int ADDR_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  vldst_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        beat;
  logic [1:0]        beat_nxt;

  logic [ADDR_W-1:0] base_r;
  logic [4:0]        vreg_r;
  logic              store_r;
  logic [127:0]      vbuf;
  logic              err_r;

  logic              accept;
  logic              misalign;

  // Lane 0 is the MSB word of the vector.
  function automatic logic [31:0] lane_get(input logic [127:0] v,
                                           input logic [1:0]   idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = v[127:96];
      2'd1:    w = v[95:64];
      2'd2:    w = v[63:32];
      default: w = v[31:0];
    endcase
    return w;
  endfunction

  function automatic logic [127:0] lane_put(input logic [127:0] v,
                                            input logic [1:0]   idx,
                                            input logic [31:0]  w);
    logic [127:0] r;
    r = v;
    case (idx)
      2'd0:    r[127:96] = w;
      2'd1:    r[95:64]  = w;
      2'd2:    r[63:32]  = w;
      default: r[31:0]   = w;
    endcase
    return r;
  endfunction

  assign misalign = (bus.base_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      beat  <= 2'd0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    beat_nxt      = beat;
    accept        = 1'b0;
    bus.busy      = 1'b0;
    bus.done      = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wr_en = 1'b0;
    bus.mem_wdata = 32'd0;
    bus.vrf_we    = 1'b0;
    bus.vrf_waddr = 5'd0;
    bus.vrf_wdata = 128'd0;
    case (state)
      IDLE: begin
        if (bus.start && !misalign) begin
          accept    = 1'b1;
          beat_nxt  = 2'd0;
          state_nxt = bus.is_store ? STORE : LOAD;
        end
      end
      LOAD, STORE: begin
        bus.busy = 1'b1;
        // Byte offset 4*beat; the add wraps modulo 2^ADDR_W.
        bus.mem_addr  = base_r + ADDR_W'({beat, 2'b00});
        bus.mem_wr_en = (state == STORE);
        if (state == STORE) begin
          bus.mem_wdata = lane_get(vbuf, beat);
        end
        beat_nxt = beat + 2'd1;
        if (beat == 2'd3) begin
          state_nxt = DONE;
        end
      end
      default: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = IDLE;
        if (!store_r) begin
          bus.vrf_we    = 1'b1;
          bus.vrf_waddr = vreg_r;
          bus.vrf_wdata = vbuf;
        end
      end
    endcase
  end

  // The regfile is read during the request so a store can snapshot the
  // vector on the acceptance edge; afterwards the latched index is held.
  assign bus.vrf_raddr = (state == IDLE) ? bus.vreg : vreg_r;
  assign bus.err       = err_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_r  <= '0;
      vreg_r  <= 5'd0;
      store_r <= 1'b0;
      vbuf    <= 128'd0;
      err_r   <= 1'b0;
    end else begin
      err_r <= (state == IDLE) && bus.start && misalign;
      if (accept) begin
        base_r  <= bus.base_addr;
        vreg_r  <= bus.vreg;
        store_r <= bus.is_store;
        vbuf    <= bus.is_store ? bus.vrf_rdata : 128'd0;
      end else if (state == LOAD) begin
        vbuf <= lane_put(vbuf, beat, bus.mem_rdata);
      end
    end
  end

endmodule

// File: tb/tb_vldst_seq.sv
// tb_vldst_seq -- scoreboard bench for vldst_seq. Expected memory reads,
// memory writes and regfile writes are queued as each request is driven,
// and a negedge monitor pops and compares them as the DUT produces them.
// Behavioural memory and regfile models sit on the interface.
module tb_vldst_seq;

  localparam logic [127:0] V5    = 128'hAAAA0000_BBBB0000_CCCC0000_DDDD0000;
  localparam logic [127:0] V6    = 128'h12345678_9ABCDEF0_0BADF00D_CAFEBABE;
  localparam logic [127:0] LD40  = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] LD80  = 128'hDEADBEEF_01234567_89ABCDEF_0F0F0F0F;

  logic clk;
  logic rst_n;
  bit   mon_en;
  int   n_chk;
  int   n_fail;

  vldst_seq_if #(.ADDR_W(32)) bus ();

  vldst_seq #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: words written by the DUT override the preload pattern.
  logic [31:0]  mem_w [256];
  bit           mem_v [256];
  logic [127:0] vrf_w [32];
  bit           vrf_v [32];

  function automatic logic [31:0] mem_init(input logic [7:0] idx);
    case (idx)
      8'h10:   return 32'h11111111;
      8'h11:   return 32'h22222222;
      8'h12:   return 32'h33333333;
      8'h13:   return 32'h44444444;
      8'h20:   return 32'hDEADBEEF;
      8'h21:   return 32'h01234567;
      8'h22:   return 32'h89ABCDEF;
      8'h23:   return 32'h0F0F0F0F;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [127:0] vrf_init(input logic [4:0] idx);
    case (idx)
      5'd5:    return V5;
      5'd6:    return V6;
      default: return 128'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus.mem_wr_en === 1'b1) begin
      mem_w[bus.mem_addr[9:2]] <= bus.mem_wdata;
      mem_v[bus.mem_addr[9:2]] <= 1'b1;
    end
    if (bus.vrf_we === 1'b1) begin
      vrf_w[bus.vrf_waddr] <= bus.vrf_wdata;
      vrf_v[bus.vrf_waddr] <= 1'b1;
    end
  end

  assign bus.mem_rdata = mem_v[bus.mem_addr[9:2]] ? mem_w[bus.mem_addr[9:2]]
                                                  : mem_init(bus.mem_addr[9:2]);
  assign bus.vrf_rdata = vrf_v[bus.vrf_raddr] ? vrf_w[bus.vrf_raddr]
                                              : vrf_init(bus.vrf_raddr);

  // Scoreboard queues.
  logic [31:0]  exp_rd [$];
  logic [63:0]  exp_wr [$];
  logic [132:0] exp_vrf [$];

  task automatic chk(input string tag, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  // Monitor: sample outputs on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.busy === 1'b1 && bus.done === 1'b0) begin
        if (bus.mem_wr_en === 1'b1) begin
          if (exp_wr.size() == 0) begin
            chk("wr_unexpected", {96'd0, bus.mem_addr}, 128'hFFFF_FFFF_FFFF);
          end else begin
            logic [63:0] e;
            e = exp_wr.pop_front();
            chk("wr_addr", bus.mem_addr, e[63:32]);
            chk("wr_data", bus.mem_wdata, e[31:0]);
          end
        end else begin
          if (exp_rd.size() == 0) begin
            chk("rd_unexpected", {96'd0, bus.mem_addr}, 128'hFFFF_FFFF_FFFF);
          end else begin
            chk("rd_addr", bus.mem_addr, exp_rd.pop_front());
          end
        end
      end else begin
        chk("idle_wr_en", bus.mem_wr_en, 1'b0);
        chk("idle_addr", bus.mem_addr, 32'd0);
      end
      if (bus.vrf_we !== 1'b0) begin
        if (exp_vrf.size() == 0) begin
          chk("vrf_unexpected", bus.vrf_we, 1'b0);
        end else begin
          logic [132:0] v;
          v = exp_vrf.pop_front();
          chk("vrf_waddr", bus.vrf_waddr, v[132:128]);
          chk("vrf_wdata", bus.vrf_wdata, v[127:0]);
        end
      end
    end
  end

  task automatic push_exp(input bit st, input logic [31:0] base,
                          input logic [4:0] vr, input logic [127:0] vexp);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = base + 32'(4 * i);
      if (st) exp_wr.push_back({a, vexp[127-32*i -: 32]});
      else    exp_rd.push_back(a);
    end
    if (!st) exp_vrf.push_back({vr, vexp});
  endtask

  // One transfer, request driven in cycle 0; returns in cycle 6.
  task automatic xfer(input bit st, input logic [31:0] base,
                      input logic [4:0] vr, input logic [127:0] vexp);
    push_exp(st, base, vr, vexp);
    bus.start     = 1'b1;
    bus.is_store  = st;
    bus.base_addr = base;
    bus.vreg      = vr;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.vreg  = ~vr;
    for (int c = 1; c <= 5; c++) begin
      chk("busy", bus.busy, 1'b1);
      chk("done", bus.done, (c == 5));
      chk("raddr_hold", bus.vrf_raddr, vr);
      chk("err_quiet", bus.err, 1'b0);
      @(posedge clk); #1;
    end
    chk("busy_end", bus.busy, 1'b0);
    chk("done_end", bus.done, 1'b0);
  endtask

  initial begin
    n_chk         = 0;
    n_fail        = 0;
    mon_en        = 1'b0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.is_store  = 1'b0;
    bus.base_addr = 32'd0;
    bus.vreg      = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_err", bus.err, 1'b0);
    chk("rst_wr_en", bus.mem_wr_en, 1'b0);
    chk("rst_vrf_we", bus.vrf_we, 1'b0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    bus.vreg = 5'd9;
    #1;
    chk("raddr_follow", bus.vrf_raddr, 5'd9);
    bus.vreg = 5'd0;
    @(posedge clk); #1;

    xfer(1'b0, 32'h40, 5'd3, LD40);
    xfer(1'b1, 32'h100, 5'd5, V5);

    // Misaligned requests, one per non-zero low address pattern.
    for (int k = 1; k < 4; k++) begin
      bus.start     = 1'b1;
      bus.is_store  = k[0];
      bus.base_addr = 32'h40 + 32'(k);
      bus.vreg      = 5'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("mis_err", bus.err, 1'b1);
      chk("mis_busy", bus.busy, 1'b0);
      @(posedge clk); #1;
      chk("mis_err_clr", bus.err, 1'b0);
      chk("mis_busy2", bus.busy, 1'b0);
    end

    xfer(1'b1, 32'hFFFF_FFF8, 5'd6, V6);

    // start held high: accepted in cycles 0 and 6 only.
    push_exp(1'b0, 32'h80, 5'd7, LD80);
    push_exp(1'b0, 32'h80, 5'd7, LD80);
    bus.start     = 1'b1;
    bus.is_store  = 1'b0;
    bus.base_addr = 32'h80;
    bus.vreg      = 5'd7;
    @(posedge clk); #1;
    for (int c = 1; c <= 12; c++) begin
      chk("b2b_busy", bus.busy, (c % 6) != 0);
      chk("b2b_done", bus.done, (c % 6) == 5);
      if (c == 12) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b_idle", bus.busy, 1'b0);

    // Reset during a load (asserted in cycle 3), with start also high.
    push_exp(1'b0, 32'h40, 5'd9, LD40);
    exp_rd.delete(3);
    exp_vrf.delete(exp_vrf.size() - 1);
    bus.start     = 1'b1;
    bus.is_store  = 1'b0;
    bus.base_addr = 32'h40;
    bus.vreg      = 5'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.vreg  = 5'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    chk("mrst_busy", bus.busy, 1'b0);
    chk("mrst_done", bus.done, 1'b0);
    chk("mrst_err", bus.err, 1'b0);
    chk("mrst_wr_en", bus.mem_wr_en, 1'b0);
    chk("mrst_vrf_we", bus.vrf_we, 1'b0);
    chk("mrst_addr", bus.mem_addr, 32'd0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("mrst_quiet_busy", bus.busy, 1'b0);
      chk("mrst_quiet_we", bus.vrf_we, 1'b0);
    end

    chk("rd_queue_empty", exp_rd.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("vrf_queue_empty", exp_vrf.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
